// File: rtl/serv_ext_pkg.sv
// Shared types and helpers for the SERV extension hub.
// Defines FSM states, fixed channel assignments and the request priority encoder.
package serv_ext_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp,
    StDrain
  } ext_state_e;

  localparam int unsigned EXT_MDU = 0;
  localparam int unsigned EXT_AVA = 1;
  localparam int unsigned MAX_EXT = 8;

  // Lowest set index wins so a multi-hot request resolves deterministically.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    logic [2:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/serv_ext_wdog.sv
// Loadable saturating cycle counter for the hub watchdog.
// Expires when enabled and the count reaches LIMIT.
module serv_ext_wdog #(
  parameter int unsigned CW    = 8,
  parameter int unsigned LIMIT = 254
) (
  input  logic          clk,
  input  logic          i_rst,
  input  logic          i_clr,
  input  logic          i_en,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  output logic          o_expire
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_load) begin
      cnt_d = i_load_val;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = i_en && (cnt_q == CW'(LIMIT));

endmodule

// File: rtl/serv_ext_hub.sv
// Dispatcher between the SERV extension port and NUM_EXT co-processor units.
// Latches one request, routes it to a unit, returns a registered result, watchdog-bounded.
module serv_ext_hub
  import serv_ext_pkg::*;
#(
  parameter int unsigned NUM_EXT    = 2,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [31:0] TIMEOUT_RD = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic [NUM_EXT-1:0]    i_valid,
  input  logic [31:0]           i_rs1,
  input  logic [31:0]           i_rs2,
  input  logic [2:0]            i_funct3,
  output logic [31:0]           o_rd,
  output logic                  o_ready,
  output logic [NUM_EXT-1:0]    o_ext_valid,
  output logic [31:0]           o_ext_rs1,
  output logic [31:0]           o_ext_rs2,
  output logic [2:0]            o_ext_funct3,
  input  logic [NUM_EXT*32-1:0] i_ext_rd,
  input  logic [NUM_EXT-1:0]    i_ext_ready,
  output logic                  o_busy,
  output logic                  o_timeout
);

  localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  ext_state_e  state_q, state_d;
  logic [2:0]  sel_q, sel_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] rs2_q, rs2_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] rd_q, rd_d;
  logic        to_q, to_d;

  logic        launch;
  logic        expire;
  logic [7:0]  valid_pad;
  logic [7:0]  ready_pad;
  logic [31:0] ext_rd [MAX_EXT];

  assign valid_pad = 8'(i_valid);
  assign ready_pad = 8'(i_ext_ready);

  // Unused channel slots read as zero so the selected index never goes out of range.
  for (genvar n = 0; n < MAX_EXT; n++) begin : g_rd
    if (n < NUM_EXT) begin : g_used
      assign ext_rd[n] = i_ext_rd[32*n +: 32];
    end else begin : g_unused
      assign ext_rd[n] = '0;
    end
  end

  if (TIMEOUT != 0) begin : g_wdog
    serv_ext_wdog #(
      .CW    (CW),
      .LIMIT (TIMEOUT - 1)
    ) u_wdog (
      .clk        (clk),
      .i_rst      (i_rst),
      .i_clr      (launch),
      .i_en       (state_q == StBusy),
      .i_load     (1'b0),
      .i_load_val ('0),
      .o_expire   (expire)
    );
  end else begin : g_no_wdog
    assign expire = 1'b0;
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    funct3_d = funct3_q;
    rd_d     = rd_q;
    to_d     = to_q;
    launch   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|i_valid) begin
          launch   = 1'b1;
          sel_d    = lowest_set(valid_pad);
          rs1_d    = i_rs1;
          rs2_d    = i_rs2;
          funct3_d = i_funct3;
          to_d     = 1'b0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        // A unit ready in the expiry cycle beats the watchdog.
        if (ready_pad[sel_q]) begin
          rd_d    = ext_rd[sel_q];
          to_d    = 1'b0;
          state_d = StResp;
        end else if (expire) begin
          rd_d    = TIMEOUT_RD;
          to_d    = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        state_d = StDrain;
      end
      StDrain: begin
        // Hold off until the core drops its level request to avoid a stale relaunch.
        if (!(|i_valid)) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      state_q  <= StIdle;
      sel_q    <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      funct3_q <= funct3_d;
      rd_q     <= rd_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    o_ext_valid = '0;
    for (int n = 0; n < NUM_EXT; n++) begin
      o_ext_valid[n] = (state_q == StBusy) && (sel_q == 3'(n));
    end
  end

  assign o_ready      = (state_q == StResp);
  assign o_timeout    = (state_q == StResp) && to_q;
  assign o_busy       = (state_q == StBusy) || (state_q == StResp);
  assign o_rd         = rd_q;
  assign o_ext_rs1    = rs1_q;
  assign o_ext_rs2    = rs2_q;
  assign o_ext_funct3 = funct3_q;

endmodule

// File: tb/tb_serv_ext_hub.sv
// Scoreboard bench for serv_ext_hub: stimulus pushes expected completions, monitor pops on o_ready.
module tb_serv_ext_hub;

  localparam int unsigned NUM_EXT = 2;
  localparam int unsigned TIMEOUT = 8;

  logic                  clk = 1'b0;
  logic                  i_rst;
  logic [NUM_EXT-1:0]    i_valid;
  logic [31:0]           i_rs1, i_rs2;
  logic [2:0]            i_funct3;
  logic [31:0]           o_rd;
  logic                  o_ready;
  logic [NUM_EXT-1:0]    o_ext_valid;
  logic [31:0]           o_ext_rs1, o_ext_rs2;
  logic [2:0]            o_ext_funct3;
  logic [NUM_EXT*32-1:0] i_ext_rd;
  logic [NUM_EXT-1:0]    i_ext_ready;
  logic                  o_busy;
  logic                  o_timeout;

  typedef struct {
    logic [31:0] rd;
    logic        to;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   t0;

  serv_ext_hub #(
    .NUM_EXT    (NUM_EXT),
    .TIMEOUT    (TIMEOUT),
    .TIMEOUT_RD (32'hFFFF_FFFF)
  ) dut (
    .clk          (clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .i_rs1        (i_rs1),
    .i_rs2        (i_rs2),
    .i_funct3     (i_funct3),
    .o_rd         (o_rd),
    .o_ready      (o_ready),
    .o_ext_valid  (o_ext_valid),
    .o_ext_rs1    (o_ext_rs1),
    .o_ext_rs2    (o_ext_rs2),
    .o_ext_funct3 (o_ext_funct3),
    .i_ext_rd     (i_ext_rd),
    .i_ext_ready  (i_ext_ready),
    .o_busy       (o_busy),
    .o_timeout    (o_timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [31:0] rd, input logic to, input int at);
    exp_t e;
    e.rd  = rd;
    e.to  = to;
    e.cyc = at;
    exp_q.push_back(e);
  endtask

  // Monitor: every o_ready pulse must match the oldest expected completion.
  always @(negedge clk) begin
    if (o_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got o_ready=1, expected no completion (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("resp_rd", o_rd, e.rd);
        chk("resp_timeout", 32'(o_timeout), 32'(e.to));
        chk("resp_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    i_rst       = 1'b1;
    i_valid     = '0;
    i_rs1       = '0;
    i_rs2       = '0;
    i_funct3    = '0;
    i_ext_rd    = '0;
    i_ext_ready = '0;
    step(2);
    chk("rst_ready", 32'(o_ready), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_ext_valid", 32'(o_ext_valid), 0);
    chk("rst_rd", o_rd, 0);
    chk("rst_timeout", 32'(o_timeout), 0);
    chk("rst_ext_rs1", o_ext_rs1, 0);
    i_rst = 1'b0;
    step(1);

    // 1: MDU request, unit ready at cycle 5 -> o_ready at cycle 6
    i_valid = 2'b01; i_rs1 = 32'd7; i_rs2 = 32'd6; i_funct3 = 3'd0;
    t0 = cyc; push(32'd42, 1'b0, t0 + 6);
    step(1);
    chk("t1_ext_valid", 32'(o_ext_valid), 32'b01);
    chk("t1_rs1", o_ext_rs1, 32'd7);
    chk("t1_rs2", o_ext_rs2, 32'd6);
    chk("t1_funct3", 32'(o_ext_funct3), 0);
    chk("t1_busy", 32'(o_busy), 1);
    i_rs1 = 32'd99;
    step(2);
    chk("t1_rs1_held", o_ext_rs1, 32'd7);
    step(2);
    i_ext_ready = 2'b01; i_ext_rd = {32'h0, 32'd42};
    step(1);
    i_ext_ready = 2'b00;
    chk("t1_busy_resp", 32'(o_busy), 1);
    step(1);
    chk("t1_drain_ext_valid", 32'(o_ext_valid), 0);
    chk("t1_drain_busy", 32'(o_busy), 0);
    i_valid = 2'b00;
    step(1);
    chk("t1_rd_hold", o_rd, 32'd42);
    step(1);

    // 2: AVA request, spurious channel-0 ready is ignored
    i_valid = 2'b10; i_rs1 = 32'h100; i_rs2 = 32'h200; i_funct3 = 3'd3;
    t0 = cyc; push(32'h1234_5678, 1'b0, t0 + 5);
    step(1);
    chk("t2_ext_valid", 32'(o_ext_valid), 32'b10);
    chk("t2_funct3", 32'(o_ext_funct3), 3);
    step(1);
    i_ext_ready = 2'b01; i_ext_rd = {32'h1234_5678, 32'hDEAD_0000};
    step(1);
    i_ext_ready = 2'b00;
    chk("t2_still_busy", 32'(o_ext_valid), 32'b10);
    step(1);
    i_ext_ready = 2'b10;
    step(1);
    i_ext_ready = 2'b00; i_valid = 2'b00;
    step(3);

    // 3: hung unit, watchdog fires 8 cycles after o_ext_valid rises
    i_valid = 2'b01; i_rs1 = 32'd1;
    t0 = cyc; push(32'hFFFF_FFFF, 1'b1, t0 + 9);
    step(8);
    chk("t3_ext_valid_late", 32'(o_ext_valid), 32'b01);
    step(1);
    i_valid = 2'b00;
    step(1);
    i_ext_ready = 2'b01; i_ext_rd = {32'h0, 32'h0000_0055};
    step(2);
    i_ext_ready = 2'b00;
    chk("t3_rd_after_late_ready", o_rd, 32'hFFFF_FFFF);
    chk("t3_idle_busy", 32'(o_busy), 0);
    chk("t3_idle_ext_valid", 32'(o_ext_valid), 0);
    step(1);

    // 4: ready coincides with watchdog expiry -> unit data wins
    i_valid = 2'b01;
    t0 = cyc; push(32'hABCD_0123, 1'b0, t0 + 9);
    step(8);
    i_ext_ready = 2'b01; i_ext_rd = {32'h0, 32'hABCD_0123};
    step(1);
    i_ext_ready = 2'b00; i_valid = 2'b00;
    step(3);

    // 5: multi-hot request, channel 0 served, no relaunch while valid held
    i_valid = 2'b11; i_ext_rd = {32'h2222_2222, 32'h1111_1111};
    t0 = cyc; push(32'h1111_1111, 1'b0, t0 + 4);
    step(1);
    chk("t5_ext_valid", 32'(o_ext_valid), 32'b01);
    step(2);
    i_ext_ready = 2'b11;
    step(1);
    i_ext_ready = 2'b00;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("t5_no_relaunch", 32'(o_ext_valid), 0);
      chk("t5_drain_busy", 32'(o_busy), 0);
    end
    i_valid = 2'b00;
    step(2);
    chk("t5_idle_ext_valid", 32'(o_ext_valid), 0);

    // 6: reset mid-BUSY, then a fresh minimum-latency request
    i_valid = 2'b01; i_rs1 = 32'h5A; i_ext_rd = {32'h0, 32'h99};
    step(3);
    i_rst = 1'b1; i_valid = 2'b00;
    step(1);
    chk("t6_ext_valid", 32'(o_ext_valid), 0);
    chk("t6_busy", 32'(o_busy), 0);
    chk("t6_rd", o_rd, 0);
    chk("t6_ready", 32'(o_ready), 0);
    chk("t6_ext_rs1", o_ext_rs1, 0);
    i_rst = 1'b0;
    step(1);
    i_valid = 2'b10; i_ext_rd = {32'h77, 32'h0};
    t0 = cyc; push(32'h77, 1'b0, t0 + 2);
    step(1);
    i_ext_ready = 2'b10;
    step(1);
    i_ext_ready = 2'b00; i_valid = 2'b00;
    step(5);

    chk("pending_completions", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
